// File: rtl/osmanip_mem_stream_dma.sv
// Command-driven stream<->RAM master for a 1024x32 single-port RAM with 1-cycle read latency.
// Define OSMANIP_MEM_DMA_CHECKSUM_EN to add a running checksum output over transferred words.
module osmanip_mem_stream_dma #(
    parameter int AW    = 10,
    parameter int DW    = 32,
    parameter int LEN_W = 11
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_write,
    input  logic [AW-1:0]    cmd_addr,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             din_valid,
    output logic             din_ready,
    input  logic [DW-1:0]    din_data,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic [DW-1:0]    dout_data,
    output logic [AW-1:0]    mem_address,
    output logic             mem_chipselect,
    output logic             mem_write,
    output logic [DW/8-1:0]  mem_byteenable,
    output logic [DW-1:0]    mem_writedata,
    input  logic [DW-1:0]    mem_readdata,
    output logic             mem_clken,
`ifdef OSMANIP_MEM_DMA_CHECKSUM_EN
    output logic [DW-1:0]    checksum,
`endif
    output logic             busy,
    output logic             done
);
    localparam logic [LEN_W-1:0] FULL_LEN = LEN_W'(2**AW);

    typedef enum logic [1:0] {S_IDLE, S_WR, S_RD, S_DRAIN} state_e;

    state_e           state_q, state_d;
    logic [AW-1:0]    addr_q, addr_d, last_addr_q, last_addr_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic [DW-1:0]    fifo_q [2];
    logic [DW-1:0]    fifo_d [2];
    logic             wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [1:0]       count_q, count_d;
    logic             inflight_q, inflight_d;
    logic             cmd_ready_q, cmd_ready_d, busy_q, busy_d, done_q, done_d;
    logic             accept, wr_beat, rd_issue, pop, push;

    always_comb begin
        accept   = cmd_valid && cmd_ready_q;
        wr_beat  = (state_q == S_WR) && din_valid && !reset;
        pop      = (count_q != 2'd0) && dout_ready;
        push     = inflight_q;
        count_d  = count_q - 2'(pop) + 2'(push);
        // Issue only if the word could still land in the FIFO after this cycle's pop/push.
        rd_issue = (state_q == S_RD) && !reset && (count_d < 2'd2);

        state_d     = state_q;
        addr_d      = addr_q;
        last_addr_d = last_addr_q;
        rem_d       = rem_q;
        inflight_d  = rd_issue;
        wr_ptr_d    = wr_ptr_q ^ push;
        rd_ptr_d    = rd_ptr_q ^ pop;
        fifo_d      = fifo_q;
        if (push) fifo_d[wr_ptr_q] = mem_readdata;

        case (state_q)
            S_IDLE: if (accept) begin
                state_d = cmd_write ? S_WR : S_RD;
                addr_d  = cmd_addr;
                rem_d   = (cmd_len == '0) ? FULL_LEN : cmd_len;
            end
            S_WR, S_RD: if (wr_beat || rd_issue) begin
                addr_d      = addr_q + AW'(1);
                last_addr_d = addr_q;
                rem_d       = rem_q - LEN_W'(1);
                if (rem_q == LEN_W'(1)) state_d = (state_q == S_WR) ? S_IDLE : S_DRAIN;
            end
            S_DRAIN: if (count_d == 2'd0 && !inflight_d) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        done_d      = (state_q != S_IDLE) && (state_d == S_IDLE);
        cmd_ready_d = (state_d == S_IDLE);
        busy_d      = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            last_addr_q <= '0;
            rem_q       <= '0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            count_q     <= 2'd0;
            inflight_q  <= 1'b0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            last_addr_q <= last_addr_d;
            rem_q       <= rem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            inflight_q  <= inflight_d;
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
        fifo_q[0] <= fifo_d[0];
        fifo_q[1] <= fifo_d[1];
    end

    assign cmd_ready      = cmd_ready_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign din_ready      = (state_q == S_WR) && !reset;
    assign dout_valid     = (count_q != 2'd0);
    assign dout_data      = fifo_q[rd_ptr_q];
    assign mem_chipselect = wr_beat || rd_issue;
    assign mem_write      = wr_beat;
    assign mem_address    = (wr_beat || rd_issue) ? addr_q : last_addr_q;
    assign mem_byteenable = '1;
    assign mem_writedata  = din_data;
    assign mem_clken      = 1'b1;

`ifdef OSMANIP_MEM_DMA_CHECKSUM_EN
    logic [DW-1:0] checksum_q, checksum_d;

    always_comb begin
        checksum_d = checksum_q;
        if (accept)       checksum_d = '0;
        else if (wr_beat) checksum_d = checksum_q + din_data;
        else if (pop)     checksum_d = checksum_q + dout_data;
    end

    always_ff @(posedge clk) begin
        if (reset) checksum_q <= '0;
        else       checksum_q <= checksum_d;
    end

    assign checksum = checksum_q;
`endif
endmodule

// File: tb/tb_osmanip_mem_stream_dma.sv
// Bench for osmanip_mem_stream_dma: behavioural RAM, reference memory image and directed/random commands.
`timescale 1ns/1ps
module tb_osmanip_mem_stream_dma;
    localparam int AW = 10, DW = 32, LEN_W = 11, DEPTH = 1024;

    logic clk = 1'b0;
    logic reset, cmd_valid, cmd_ready, cmd_write, din_valid, din_ready;
    logic dout_valid, dout_ready, mem_chipselect, mem_write, mem_clken, busy, done;
    logic [AW-1:0]    cmd_addr, mem_address;
    logic [LEN_W-1:0] cmd_len;
    logic [DW-1:0]    din_data, dout_data, mem_writedata, mem_readdata;
    logic [DW/8-1:0]  mem_byteenable;
`ifdef OSMANIP_MEM_DMA_CHECKSUM_EN
    logic [DW-1:0]    checksum;
`endif

    always #5 clk = ~clk;

    osmanip_mem_stream_dma #(.AW(AW), .DW(DW), .LEN_W(LEN_W)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .din_valid(din_valid), .din_ready(din_ready), .din_data(din_data),
        .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_data(dout_data),
        .mem_address(mem_address), .mem_chipselect(mem_chipselect), .mem_write(mem_write),
        .mem_byteenable(mem_byteenable), .mem_writedata(mem_writedata),
        .mem_readdata(mem_readdata), .mem_clken(mem_clken),
`ifdef OSMANIP_MEM_DMA_CHECKSUM_EN
        .checksum(checksum),
`endif
        .busy(busy), .done(done)
    );

    // RAM slave: registered read data, one cycle after the address.
    logic [DW-1:0] ram     [DEPTH];
    logic [DW-1:0] ref_mem [DEPTH];
    always @(posedge clk) begin
        if (mem_chipselect && mem_clken) begin
            if (mem_write) ram[mem_address] <= mem_writedata;
            else           mem_readdata     <= ram[mem_address];
        end
    end

    int total = 0;
    int bad   = 0;
    logic [DW-1:0] exp_sum;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [LEN_W-1:0] enc_len(input int n);
        return (n == DEPTH) ? '0 : LEN_W'(n);
    endfunction

    task automatic finish_cmd();
        @(negedge clk);
        din_valid  = 1'b0;
        dout_ready = 1'b0;
        #1;
        chk("done_pulse", done, 1);
        chk("idle_busy", busy, 0);
        chk("idle_cmd_ready", cmd_ready, 1);
        chk("idle_cs", mem_chipselect, 0);
`ifdef OSMANIP_MEM_DMA_CHECKSUM_EN
        chk("checksum", checksum, exp_sum);
`endif
        @(negedge clk);
        #1 chk("done_once", done, 0);
    endtask

    task automatic do_write(input logic [AW-1:0] a, input int n, input int pct,
                            input bit rnd, input logic [DW-1:0] base);
        int i = 0;
        int guard = 0;
        logic [AW-1:0] wa;
        exp_sum = '0;
        @(negedge clk);
        #1 chk("wr_cmd_ready", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = a; cmd_len = enc_len(n);
        while (i < n && guard < 20000) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            guard++;
            din_valid = ($urandom_range(0, 99) < pct);
            din_data  = rnd ? $urandom() : base + DW'(i);
            #1;
            chk("wr_din_ready", din_ready, 1);
            chk("wr_busy_cmd_ready", cmd_ready, 0);
            chk("wr_done_early", done, 0);
            chk("wr_cs", mem_chipselect, din_valid);
            if (din_valid) begin
                wa = a + AW'(i);
                chk("wr_addr", mem_address, wa);
                chk("wr_we", mem_write, 1);
                chk("wr_data", mem_writedata, din_data);
                ref_mem[wa] = din_data;
                exp_sum += din_data;
                i++;
            end
        end
        chk("wr_timeout", i, n);
        finish_cmd();
        for (int k = 0; k < n; k++) begin
            wa = a + AW'(k);
            chk("wr_ram", ram[wa], ref_mem[wa]);
        end
    endtask

    // mode 0: dout_ready held high, 1: toggles every cycle, 2: random
    task automatic do_read(input logic [AW-1:0] a, input int n, input int mode, input bit chk_lat);
        int got = 0, iss = 0, cyc = 0, first = -1, last = 0, max_out = 0;
        logic [AW-1:0] ra;
        exp_sum = '0;
        @(negedge clk);
        #1 chk("rd_cmd_ready", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = a; cmd_len = enc_len(n);
        while (got < n && cyc < 20000) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            cyc++;
            case (mode)
                0:       dout_ready = 1'b1;
                1:       dout_ready = cyc[0];
                default: dout_ready = 1'($urandom_range(0, 1));
            endcase
            #1;
            chk("rd_done_early", done, 0);
            chk("rd_busy", busy, 1);
            if (mem_chipselect) begin
                ra = a + AW'(iss);
                chk("rd_addr", mem_address, ra);
                chk("rd_we", mem_write, 0);
                iss++;
            end
            if (dout_valid && dout_ready) begin
                ra = a + AW'(got);
                chk("rd_data", dout_data, ref_mem[ra]);
                exp_sum += ref_mem[ra];
                if (first < 0) first = cyc;
                last = cyc;
                got++;
            end
            if (iss - got > max_out) max_out = iss - got;
        end
        chk("rd_timeout", got, n);
        chk("rd_issued", iss, n);
        chk("rd_outstanding_le2", 64'(max_out <= 2), 1);
        if (chk_lat) begin
            chk("rd_first_latency", first, 3);
            chk("rd_back_to_back", last - first, n - 1);
        end
        finish_cmd();
    endtask

    initial begin
        logic [AW-1:0] ra;
        int rn;
        reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
        din_valid = 1'b0; din_data = '0; dout_ready = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_dout_valid", dout_valid, 0);
        chk("rst_cs", mem_chipselect, 0);
        chk("rst_done", done, 0);
        chk("rst_addr", mem_address, 0);
        reset = 1'b0;
        @(negedge clk);
        #1;
        chk("idle_din_ready", din_ready, 0);
        chk("byteenable", mem_byteenable, 4'hF);
        chk("clken", mem_clken, 1);

        // Directed write/read of 0xA0..0xA3
        do_write(10'h010, 4, 100, 1'b0, 32'hA0);
        do_read(10'h010, 4, 0, 1'b1);

        // Backpressure: toggled dout_ready
        do_write(10'h040, 6, 70, 1'b1, '0);
        do_read(10'h040, 6, 1, 1'b0);

        // Address wrap
        do_write(10'd1022, 4, 100, 1'b1, '0);
        do_read(10'd1022, 4, 0, 1'b1);

        // Reset during a write: the beat in the reset cycle must not reach RAM
        do_write(10'h200, 1, 100, 1'b0, 32'h5555_0000);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 10'h200; cmd_len = 11'd4;
        @(negedge clk);
        cmd_valid = 1'b0; reset = 1'b1; din_valid = 1'b1; din_data = 32'hDEAD_BEEF;
        #1 chk("rst_wr_suppress", mem_write, 0);
        @(negedge clk);
        reset = 1'b0; din_valid = 1'b0;
        #1;
        chk("rst_wr_busy", busy, 0);
        chk("rst_wr_done", done, 0);
        chk("rst_wr_ram", ram[10'h200], ref_mem[10'h200]);
        @(negedge clk);
        #1 chk("rst_wr_no_done", done, 0);

        // Reset during a read with data buffered
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 10'h010; cmd_len = 11'd4; dout_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            cmd_valid = 1'b0;
        end
        #1 chk("rst_rd_pre_valid", dout_valid, 1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_rd_dout_valid", dout_valid, 0);
        chk("rst_rd_busy", busy, 0);
        chk("rst_rd_done", done, 0);
        chk("rst_rd_cmd_ready", cmd_ready, 1);
        chk("rst_rd_addr", mem_address, 0);
        @(negedge clk);
        #1;
        chk("rst_rd_no_done", done, 0);
        chk("rst_rd_valid_stays_low", dout_valid, 0);
        do_read(10'h010, 4, 0, 1'b1);

        // Length 0 means the full 1024 words
        do_write(10'h123, DEPTH, 100, 1'b1, '0);
        do_read(10'h123, DEPTH, 2, 1'b0);

        // Random commands
        for (int t = 0; t < 6; t++) begin
            ra = AW'($urandom_range(0, DEPTH - 1));
            rn = $urandom_range(1, 24);
            do_write(ra, rn, $urandom_range(30, 100), 1'b1, '0);
            do_read(ra, rn, $urandom_range(0, 2), 1'b0);
        end

        // Checksum of 1,2,3
        do_write(10'h300, 3, 100, 1'b0, 32'd1);
`ifdef OSMANIP_MEM_DMA_CHECKSUM_EN
        chk("checksum_123", checksum, 6);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
